rot_out_fifo: RTL and testbench
===============================

// Module: rot_out_fifo
// PURPOSE
//   Show-ahead FIFO that captures the 4-bit rotator output stream for a slower downstream consumer.
//   The rotator's output and enable drive in_data/in_valid; a downstream reader drains words with a valid/ready handshake.
//   Holds up to DEPTH words and reports occupancy.
//   A sticky flag records any word lost to a full buffer.
// PARAMETERS
//   WIDTH   4   data word width in bits (matches the rotator nibble)
//   DEPTH   4   number of storage entries; power of 2, >= 2
//   AW      2   pointer width; must equal log2(DEPTH)
// PORTS
//   clk        in   1        system clock; all state changes on posedge
//   rst_n      in   1        asynchronous active-low reset
//   clr        in   1        synchronous clear: empties FIFO, clears overflow
//   in_valid   in   1        write request (driven by the rotator enable)
//   in_data    in   WIDTH    write data (rotator output)
//   in_ready   out  1        high when a write will be accepted (= !full)
//   out_valid  out  1        high when out_data holds a valid word (= !empty)
//   out_data   out  WIDTH    oldest stored word (show-ahead)
//   out_ready  in   1        consumer accepts out_data this cycle
//   count      out  AW+1     number of stored words, 0..DEPTH
//   overflow   out  1        sticky: a write was attempted while full
// BEHAVIOUR
//   Reset state (rst_n low, asynchronous):
//     - wr_ptr = rd_ptr = 0, count = 0, overflow = 0
//     - out_valid = 0, in_ready = 1; out_data = 0 while empty
//   Reset mid-operation discards all contents immediately; storage contents need no reset.
//   Push = in_valid & in_ready; pop = out_valid & out_ready; both are evaluated at the same posedge.
//   Push: mem[wr_ptr] <= in_data; wr_ptr increments modulo DEPTH.
//   Pop: rd_ptr increments modulo DEPTH.
//   Count update per cycle:
//     - +1 on push only
//     - -1 on pop only
//     - unchanged on push and pop together, or on neither
//   Full (count == DEPTH):
//     - in_ready = 0; no pass-through, even with out_ready = 1
//     - in_valid while full sets overflow = 1 and drops the word; pointers and count are unchanged
//   Empty (count == 0):
//     - out_valid = 0; out_ready is ignored; out_data = 0
//     - No bypass: a word written at edge N appears on out_data/out_valid after edge N (latency 1 cycle).
//   out_data is combinational from mem[rd_ptr] and is stable while out_valid = 1 and no pop occurs.
//   clr = 1 at a posedge:
//     - count, pointers and overflow go to 0; any push or pop in the same cycle is ignored
//     - clr has priority over push, pop and overflow set
//   overflow stays 1 until rst_n or clr.
//   Pointers wrap from DEPTH-1 to 0 with no gap; full and empty are derived from count, never from pointer equality alone.
// TESTING
//   T1 reset: push 4'b0011, 4'b1001, then pulse rst_n low between edges
//      -> count=0, out_valid=0, in_ready=1, overflow=0 immediately, with no clk edge needed
//   T2 order: push 4'b0101, 4'b1010, 4'b1100 with out_ready=0, then out_ready=1
//      -> out_data reads 0101, 1010, 1100 on successive cycles; count steps 3,2,1,0
//   T3 full: push 1,2,3,4, then in_valid=1 with 4'b1111 -> in_ready=0, count=4, overflow=1
//      -> draining yields 1,2,3,4 only (1111 is absent)
//   T4 simultaneous: at count=2 (words 0001, 0010), push 0100 while popping
//      -> count stays 2; out_data=0010, then 0100
//   T5 wrap: 10 cycles of push k (k=0..9) with pop every cycle after the first
//      -> outputs 0..9 in order; count never exceeds 1
//   T6 clr: at count=3 with overflow=1, assert clr together with in_valid=1 and out_ready=1
//      -> next cycle count=0, overflow=0, out_valid=0; the pushed word is discarded

Source files
------------

// File: rtl/rot_out_fifo.sv
// Show-ahead FIFO buffering the 4-bit rotator output stream for a slower consumer.
// Reports occupancy and keeps a sticky flag for any word dropped while full.
module rot_out_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [AW:0]      count,
    output logic             overflow
);

    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             overflow_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Handshake: a word moves on a posedge only when valid and ready are both
    // high on that side; valid never depends on ready, and a full FIFO refuses
    // writes even if a pop happens in the same cycle.
    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data  = empty ? '0 : mem[rd_ptr];
    assign count     = count_q;
    assign overflow  = overflow_q;

    // Storage carries no reset; validity is tracked purely by count.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (in_valid && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rot_out_fifo.sv
// Directed bench for rot_out_fifo: reset, ordering, full/overflow, simultaneous
// push/pop, pointer wrap and synchronous clear, with hand-computed expectations.
module tb_rot_out_fifo;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;
    logic [2:0] count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    rot_out_fifo #(.WIDTH(4), .DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one posedge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b0;
        #12;
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_overflow", overflow, 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        step();

        // T1: asynchronous reset mid-operation
        in_valid = 1'b1; in_data = 4'b0011;
        step();
        check("t1_count1", count, 1);
        check("t1_latency_data", out_data, 4'b0011);
        in_data = 4'b1001;
        step();
        in_valid = 1'b0;
        check("t1_count2", count, 2);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_count", count, 0);
        check("t1_async_out_valid", out_valid, 0);
        check("t1_async_in_ready", in_ready, 1);
        check("t1_async_overflow", overflow, 0);
        rst_n = 1'b1;
        step();

        // T2: ordering with a stalled then draining consumer
        in_valid = 1'b1; in_data = 4'b0101;
        step();
        in_data = 4'b1010;
        step();
        in_data = 4'b1100;
        step();
        in_valid = 1'b0;
        check("t2_count3", count, 3);
        check("t2_data0", out_data, 4'b0101);
        out_ready = 1'b1;
        step();
        check("t2_count2", count, 2);
        check("t2_data1", out_data, 4'b1010);
        step();
        check("t2_count1", count, 1);
        check("t2_data2", out_data, 4'b1100);
        step();
        check("t2_count0", count, 0);
        check("t2_empty_valid", out_valid, 0);
        check("t2_empty_data", out_data, 0);
        step();
        check("t2_empty_pop_ignored", count, 0);
        out_ready = 1'b0;

        // T3: fill, overflow, no pass-through while full, drain
        in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_data = 4'(k);
            step();
        end
        check("t3_full_count", count, 4);
        check("t3_full_in_ready", in_ready, 0);
        check("t3_no_ovf_yet", overflow, 0);
        in_data = 4'b1111;
        step();
        check("t3_overflow", overflow, 1);
        check("t3_count_hold", count, 4);
        check("t3_head", out_data, 4'h1);
        in_data = 4'b1110; out_ready = 1'b1;
        step();
        check("t3_no_passthru_count", count, 3);
        check("t3_no_passthru_data", out_data, 4'h2);
        in_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            check("t3_drain", out_data, 32'(k));
            step();
        end
        check("t3_drained", count, 0);
        check("t3_ovf_sticky", overflow, 1);
        out_ready = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t3_clr_ovf", overflow, 0);

        // T4: simultaneous push and pop
        in_valid = 1'b1; in_data = 4'b0001;
        step();
        in_data = 4'b0010;
        step();
        check("t4_count2", count, 2);
        in_data = 4'b0100; out_ready = 1'b1;
        step();
        check("t4_count_same", count, 2);
        check("t4_data_a", out_data, 4'b0010);
        in_valid = 1'b0;
        step();
        check("t4_count1", count, 1);
        check("t4_data_b", out_data, 4'b0100);
        step();
        check("t4_count0", count, 0);
        out_ready = 1'b0;

        // T5: pointer wrap with streaming push/pop
        for (int k = 0; k < 10; k++) begin
            in_valid  = 1'b1;
            in_data   = 4'(k);
            out_ready = (k > 0);
            if (k > 0) check("t5_stream_data", out_data, 32'(k - 1));
            step();
            check("t5_count", count, 1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("t5_last_data", out_data, 4'd9);
        step();
        check("t5_count0", count, 0);
        out_ready = 1'b0;

        // T6: clr beats push, pop and overflow set
        in_valid = 1'b1;
        for (int k = 5; k <= 8; k++) begin
            in_data = 4'(k);
            step();
        end
        in_data = 4'b1111;
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t6_pre_count", count, 3);
        check("t6_pre_ovf", overflow, 1);
        check("t6_pre_data", out_data, 4'd6);
        clr = 1'b1; in_valid = 1'b1; in_data = 4'b1001; out_ready = 1'b1;
        step();
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("t6_count", count, 0);
        check("t6_overflow", overflow, 0);
        check("t6_out_valid", out_valid, 0);
        check("t6_in_ready", in_ready, 1);
        step();
        check("t6_discarded_count", count, 0);
        check("t6_discarded_data", out_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
